nexusv_fetch_unit: RTL
======================

// Module: nexusv_fetch_unit
// PURPOSE
//  Instruction fetch stage feeding the nexusV decoder: owns the fetch PC, issues word reads
//  to instruction memory over a valid/ready handshake, and buffers returned words with
//  their PCs in a small prefetch queue. Presents {instr, pc} to the decoder via valid/ready.
//  Accepts redirects (branch/jump/trap) from execute; it flushes the queue and discards stale responses.
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch address after reset
//  FIFO_DEPTH  2              prefetch queue entries (power of 2, >=2)
//  XLEN        32             address/data width
// PORTS
//  clk             in   1     clock, rising edge
//  rst_n           in   1     asynchronous active-low reset
//  imem_req_valid  out  1     read request valid
//  imem_req_ready  in   1     memory accepts request
//  imem_req_addr   out  XLEN  word-aligned read address
//  imem_rsp_valid  in   1     read data valid (always in request order)
//  imem_rsp_data   in   XLEN  read data
//  ir_valid        out  1     queue head valid to decoder
//  ir_ready        in   1     decoder consumes head this cycle
//  ir_instr        out  32    head instruction
//  ir_pc           out  XLEN  PC of head instruction
//  fetch_pc        out  XLEN  next address to be requested
//  redirect_valid  in   1     redirect fetch
//  redirect_pc     in   XLEN  redirect target
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, queue empty, state IDLE, imem_req_valid=0, ir_valid=0,
//    ir_instr=`NOP_INSTR, ir_pc=0, drop flag=0. Reset mid-transaction abandons the request. Any rsp with none outstanding is ignored.
//  - FSM: IDLE -> REQ when slots free (count + outstanding < FIFO_DEPTH); REQ holds
//    imem_req_valid=1, addr=fetch_pc stable until ready; REQ->WAIT on valid&ready,
//    fetch_pc+=4 (wraps mod 2^XLEN). WAIT->REQ on rsp if space remains, else ->IDLE.
//  - At most one outstanding request. Response pushes {data, pc_of_req} into queue.
//  - Latency: request-accept to ir_valid = rsp latency + 1 cycle (registered queue).
//  - Decoder pop on ir_valid&ir_ready. Push and pop in the same cycle when full is legal (count unchanged).
//  - Redirect (highest priority): queue flushed, fetch_pc<=redirect_pc, ir_valid=0 next
//    cycle; in REQ, request dropped (valid may deassert); in WAIT, drop flag set so the
//    in-flight response is discarded, then -> REQ. Redirect coinciding with rsp: rsp
//    discarded. Redirect coinciding with pop: pop ignored (flush wins).
//  - Queue full: no request issued. Empty: ir_valid=0, ir_instr holds `NOP_INSTR.
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined: redirect_pc[1:0]!=0 raises fetch_fault (1-cycle pulse)
//    and fault_pc=redirect_pc; no request issued until next aligned redirect. Adds ports
//    fetch_fault out 1, fault_pc out XLEN (reset 0).
//  Undefined: redirect_pc[1:0] forced to 2'b00, no fault ports.
// STRUCTURE
//  - rv_defs.vh: `NOP_INSTR (32'h0000_0013), `RESET_VECTOR, fetch FSM state codes,
//    `CAUSE_INSTR_MISALIGNED (0).
//  - Sub-module nexusv_fetch_queue: synchronous FIFO of {pc, instr}, push/pop/flush,
//    count, full/empty; FSM and PC logic stay in nexusv_fetch_unit.
// TESTING
//  1 Reset, memory 0-wait, ir_ready=1 -> addrs 0x0,0x4,0x8...; ir_pc tracks addr, one instr per 2 cycles.
//  2 ir_ready=0 -> exactly FIFO_DEPTH requests (0x0,0x4) issued then stall; raise ready -> resumes at 0x8.
//  3 Redirect to 0x100 while WAIT on 0x8 -> stale 0x8 data never reaches ir_*, next ir_pc=0x100.
//  4 Redirect in same cycle as rsp and pop -> queue empty next cycle, fetch_pc=redirect_pc.
//  5 rst_n low mid-WAIT, late rsp after release -> ignored, first request at RESET_PC.
//  6 (FETCH_MISALIGN_TRAP_EN) redirect 0x102 -> fetch_fault pulse, fault_pc=0x102, no req.

Source files
------------

// File: rtl/nexusv_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// nexusv_fetch_unit_pkg
// Shared definitions for the nexusV instruction fetch stage:
//   NOP_INSTR     - canonical RISC-V NOP (addi x0,x0,0) shown when no instr is held
//   RESET_VECTOR  - default fetch address after reset
//   fetch_state_t - fetch FSM state encoding
//   is_misaligned - helper flagging a non word-aligned fetch target
// -----------------------------------------------------------------------------
package nexusv_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/nexusv_fetch_queue.sv
// -----------------------------------------------------------------------------
// nexusv_fetch_queue
// Synchronous prefetch FIFO of {pc, instr} pairs between instruction memory
// and the decoder. Flush empties the queue and wins over push/pop in the same
// cycle. Push while full is accepted only when a pop happens in that cycle.
// The head is presented combinationally from storage; when empty the head
// reads as {pc=0, instr=NOP_INSTR}.
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   i_push            write {i_push_pc, i_push_instr} at the tail
//   i_pop             consume the head entry
//   i_flush           discard every entry
//   o_head_pc/instr   head entry contents
//   o_count           number of held entries
//   o_full, o_empty   occupancy flags
// -----------------------------------------------------------------------------
module nexusv_fetch_queue #(
    parameter  int DEPTH = 2,
    parameter  int XLEN  = 32,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  logic [XLEN-1:0] i_push_pc,
    input  logic [31:0]     i_push_instr,
    input  logic            i_pop,
    input  logic            i_flush,
    output logic [XLEN-1:0] o_head_pc,
    output logic [31:0]     o_head_instr,
    output logic [CW-1:0]   o_count,
    output logic            o_full,
    output logic            o_empty
);
    import nexusv_fetch_unit_pkg::*;

    logic [XLEN-1:0] r_pc    [DEPTH];
    logic [31:0]     r_instr [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == {CW{1'b0}});
    assign w_do_pop  = i_pop & ~w_empty;
    // A simultaneous pop frees the slot the push needs.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= {XLEN{1'b0}};
                r_instr[i] <= NOP_INSTR;
            end
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (i_flush) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_pc[r_wr_ptr]    <= i_push_pc;
                r_instr[r_wr_ptr] <= i_push_instr;
                r_wr_ptr          <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head view; an empty queue shows a NOP so the decoder never sees stale data.
    always_comb begin
        o_head_pc    = {XLEN{1'b0}};
        o_head_instr = NOP_INSTR;
        if (w_empty) begin
            o_head_pc    = {XLEN{1'b0}};
            o_head_instr = NOP_INSTR;
        end else begin
            o_head_pc    = r_pc[r_rd_ptr];
            o_head_instr = r_instr[r_rd_ptr];
        end
    end

    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/nexusv_fetch_unit.sv
// -----------------------------------------------------------------------------
// nexusv_fetch_unit
// Instruction fetch stage for nexusV. Owns the fetch PC, issues one word read
// at a time to instruction memory (valid/ready), and buffers returned words
// with their PCs in nexusv_fetch_queue for the decoder (valid/ready).
// Redirects flush the queue, retarget the PC and discard any in-flight data.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : misaligned redirect pulses fetch_fault, captures fault_pc and
//               halts requests until the next aligned redirect
//   undefined : redirect_pc[1:0] is ignored (treated as 2'b00)
// Ports:
//   clk, rst_n                         clock / asynchronous active-low reset
//   imem_req_valid/ready/addr          instruction read request
//   imem_rsp_valid/data                in-order read response
//   ir_valid/ready, ir_instr, ir_pc    queue head to decoder
//   fetch_pc                           next address to be requested
//   redirect_valid, redirect_pc        branch/jump/trap retarget
//   fetch_fault, fault_pc              (FETCH_MISALIGN_TRAP_EN only)
// -----------------------------------------------------------------------------
module nexusv_fetch_unit
    import nexusv_fetch_unit_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = RESET_VECTOR,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            ir_valid,
    input  logic            ir_ready,
    output logic [31:0]     ir_instr,
    output logic [XLEN-1:0] ir_pc,
    output logic [XLEN-1:0] fetch_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            fetch_fault,
    output logic [XLEN-1:0] fault_pc,
`endif
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] w_fetch_pc_nxt;
    logic [XLEN-1:0] r_req_pc;        // PC of the outstanding request
    logic            r_drop;          // outstanding response belongs to a flushed path
    logic            w_drop_nxt;

    logic [XLEN-1:0] w_redirect_target;
    logic            w_target_bad;
    logic            w_halted;

    logic            w_accept;
    logic            w_q_push;
    logic            w_q_pop;
    logic            w_q_full;
    logic            w_q_empty;
    logic [CW-1:0]   w_q_count;
    logic [CW:0]     w_occ_after_push;

    assign w_accept = (r_state == ST_REQ) & imem_req_ready;
    // Responses only count while a request is outstanding; flush beats push and pop.
    assign w_q_push = (r_state == ST_WAIT) & imem_rsp_valid & ~r_drop & ~redirect_valid;
    assign w_q_pop  = ~w_q_empty & ir_ready & ~redirect_valid;
    assign w_occ_after_push = {1'b0, w_q_count} + (CW+1)'(1) - (CW+1)'(w_q_pop);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            r_halt;
    logic            r_fault;
    logic [XLEN-1:0] r_fault_pc;

    assign w_redirect_target = redirect_pc;
    assign w_target_bad      = redirect_valid & is_misaligned(redirect_pc[1:0]);
    assign w_halted          = r_halt;

    // Fault pulse, captured target, and request halt until an aligned redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halt     <= 1'b0;
            r_fault    <= 1'b0;
            r_fault_pc <= {XLEN{1'b0}};
        end else begin
            r_fault <= w_target_bad;
            if (redirect_valid) begin
                r_halt <= w_target_bad;
            end else begin
                r_halt <= r_halt;
            end
            if (w_target_bad) begin
                r_fault_pc <= redirect_pc;
            end else begin
                r_fault_pc <= r_fault_pc;
            end
        end
    end

    assign fetch_fault = r_fault;
    assign fault_pc    = r_fault_pc;
`else
    logic w_unused_low;

    assign w_redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused_low      = ^redirect_pc[1:0];
    assign w_target_bad      = 1'b0;
    assign w_halted          = 1'b0;
`endif

    // Fetch FSM next state, next PC and drop-flag update.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_drop_nxt     = r_drop;
        if (redirect_valid) begin
            w_fetch_pc_nxt = w_redirect_target;
            case (r_state)
                ST_REQ: begin
                    if (w_accept) begin
                        // Memory took the old address: wait it out and discard it.
                        w_state_nxt = ST_WAIT;
                        w_drop_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = w_target_bad ? ST_IDLE : ST_REQ;
                        w_drop_nxt  = 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        w_state_nxt = w_target_bad ? ST_IDLE : ST_REQ;
                        w_drop_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_drop_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = w_target_bad ? ST_IDLE : ST_REQ;
                    w_drop_nxt  = 1'b0;
                end
            endcase
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_halted && !w_q_full) begin
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (w_accept) begin
                        w_state_nxt    = ST_WAIT;
                        w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        w_drop_nxt = 1'b0;
                        if (r_drop) begin
                            w_state_nxt = (w_halted || w_q_full) ? ST_IDLE : ST_REQ;
                        end else if (w_occ_after_push < (CW+1)'(FIFO_DEPTH)) begin
                            w_state_nxt = ST_REQ;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_drop_nxt  = 1'b0;
                end
            endcase
        end
    end

    // Fetch FSM state, fetch PC and outstanding-request bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= {XLEN{1'b0}};
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_drop     <= w_drop_nxt;
            if (w_accept) begin
                r_req_pc <= r_fetch_pc;
            end else begin
                r_req_pc <= r_req_pc;
            end
        end
    end

    nexusv_fetch_queue #(
        .DEPTH (FIFO_DEPTH),
        .XLEN  (XLEN)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_q_push),
        .i_push_pc    (r_req_pc),
        .i_push_instr (imem_rsp_data[31:0]),
        .i_pop        (w_q_pop),
        .i_flush      (redirect_valid),
        .o_head_pc    (ir_pc),
        .o_head_instr (ir_instr),
        .o_count      (w_q_count),
        .o_full       (w_q_full),
        .o_empty      (w_q_empty)
    );

    assign imem_req_valid = (r_state == ST_REQ);
    assign imem_req_addr  = r_fetch_pc;
    assign fetch_pc       = r_fetch_pc;
    assign ir_valid       = ~w_q_empty;

endmodule
